// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned IMEM_AW          = 8;
    localparam int unsigned IMEM_DW          = 8;
    localparam int unsigned IDLE_TIMEOUT_DEF = 1024;
    localparam int unsigned TIMER_W          = 16;

    typedef enum logic [1:0] {
        HALT,
        LOAD,
        RUN
    } state_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one registered read port, read-before-write.
module imem_ram
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [IMEM_AW-1:0] waddr,
    input  logic [IMEM_DW-1:0] wdata,
    input  logic [IMEM_AW-1:0] raddr,
    output logic [IMEM_DW-1:0] rdata
);

    logic [IMEM_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; the array keeps its contents across resets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Commits host instruction writes into the RAM, serves core fetches, and holds the
// core in reset while a program load is in progress.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IMEM_AW-1:0] wr_addr,
    input  logic [IMEM_DW-1:0] wr_data,
    input  logic               wr_en,
    input  logic               host_halt,
    input  logic [IMEM_AW-1:0] fetch_addr,
    output logic [IMEM_DW-1:0] fetch_data,
    output logic               cpu_rst_n,
    output logic               loading,
    output logic [CNT_W-1:0]   load_count,
    output logic [IMEM_DW-1:0] load_sum
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(IDLE_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IMEM_DW-1:0] sum_q, sum_d;
    logic               wr_en_q;
    logic               cpu_rst_n_q;
    logic               accept;

    // wr_en_q resets high so a stuck-high or unknown enable cannot look like a rising edge.
    assign accept = wr_en & ~wr_en_q;

    imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (fetch_addr),
        .rdata (fetch_data)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        sum_d   = sum_q;
        if (host_halt) begin
            state_d = HALT;
        end else begin
            unique case (state_q)
                HALT, RUN: begin
                    if (accept) begin
                        state_d = LOAD;
                        count_d = CNT_W'(1);
                        sum_d   = wr_data;
                        timer_d = '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                        sum_d   = sum_q + wr_data;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        state_d = RUN;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                default: state_d = HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HALT;
            timer_q     <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            wr_en_q     <= 1'b1;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            wr_en_q     <= wr_en;
            cpu_rst_n_q <= (state_d == RUN);
        end
    end

    assign cpu_rst_n  = cpu_rst_n_q;
    assign loading    = (state_q == LOAD);
    assign load_count = count_q;
    assign load_sum   = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a short idle timeout.
module tb_imem_loader;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        host_halt;
    logic [7:0]  fetch_addr;
    logic [7:0]  fetch_data;
    logic        cpu_rst_n;
    logic        loading;
    logic [15:0] load_count;
    logic [7:0]  load_sum;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader #(
        .DEPTH        (256),
        .IDLE_TIMEOUT (TO),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .host_halt  (host_halt),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_rst_n  (cpu_rst_n),
        .loading    (loading),
        .load_count (load_count),
        .load_sum   (load_sum)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pulse(input logic [7:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 8'h00;
        wr_data    = 8'h55;
        host_halt  = 1'b0;
        fetch_addr = 8'h00;

        // Reset hygiene with enable stuck high
        step();
        step();
        check_eq("rst_fetch", 32'(fetch_data), 32'h00);
        rst_n = 1'b1;
        step();
        step();
        step();
        check_eq("rst_loading", 32'(loading), 32'd0);
        check_eq("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check_eq("rst_count", 32'(load_count), 32'd0);
        check_eq("rst_sum", 32'(load_sum), 32'd0);
        wr_en = 1'b0;
        step();
        check_eq("rst_no_write", 32'(loading), 32'd0);

        // Basic load
        write_pulse(8'h00, 8'hA1);
        check_eq("load1_loading", 32'(loading), 32'd1);
        check_eq("load1_count", 32'(load_count), 32'd1);
        check_eq("load1_sum", 32'(load_sum), 32'hA1);
        repeat (3) step();
        write_pulse(8'h01, 8'h22);
        repeat (3) step();
        write_pulse(8'h02, 8'h33);
        check_eq("load3_count", 32'(load_count), 32'd3);
        check_eq("load3_sum", 32'(load_sum), 32'hF6);
        repeat (TO - 1) step();
        check_eq("load_pre_run", 32'(cpu_rst_n), 32'd0);
        check_eq("load_pre_loading", 32'(loading), 32'd1);
        step();
        check_eq("load_run", 32'(cpu_rst_n), 32'd1);
        check_eq("load_run_loading", 32'(loading), 32'd0);
        fetch_addr = 8'h01;
        step();
        check_eq("fetch_01", 32'(fetch_data), 32'h22);
        fetch_addr = 8'h00;
        step();
        check_eq("fetch_00", 32'(fetch_data), 32'hA1);

        // Timeout restart: writes at cycles 0 and 7
        write_pulse(8'h05, 8'h11);
        check_eq("rst_reload_cpu", 32'(cpu_rst_n), 32'd0);
        repeat (6) step();
        write_pulse(8'h06, 8'h22);
        check_eq("restart_count", 32'(load_count), 32'd2);
        check_eq("restart_sum", 32'(load_sum), 32'h33);
        step();
        check_eq("restart_c8", 32'(cpu_rst_n), 32'd0);
        repeat (TO - 2) step();
        check_eq("restart_c14", 32'(cpu_rst_n), 32'd0);
        step();
        check_eq("restart_c15", 32'(cpu_rst_n), 32'd1);

        // Reload while running, read-before-write on the fetch port
        fetch_addr = 8'h05;
        write_pulse(8'h05, 8'h7E);
        check_eq("rbw_old", 32'(fetch_data), 32'h11);
        check_eq("reload_cpu", 32'(cpu_rst_n), 32'd0);
        check_eq("reload_loading", 32'(loading), 32'd1);
        check_eq("reload_count", 32'(load_count), 32'd1);
        check_eq("reload_sum", 32'(load_sum), 32'h7E);
        step();
        check_eq("rbw_new", 32'(fetch_data), 32'h7E);

        // Enable held high for five cycles counts once
        wr_addr = 8'h07;
        wr_data = 8'h05;
        wr_en   = 1'b1;
        repeat (5) step();
        wr_en = 1'b0;
        check_eq("held_count", 32'(load_count), 32'd2);
        check_eq("held_sum", 32'(load_sum), 32'h83);
        for (int i = 0; i < 20; i++) begin
            if (cpu_rst_n) break;
            step();
        end
        check_eq("held_run", 32'(cpu_rst_n), 32'd1);

        // host_halt wins over a simultaneous write; RAM still written
        host_halt = 1'b1;
        write_pulse(8'h08, 8'h9C);
        host_halt = 1'b0;
        check_eq("halt_loading", 32'(loading), 32'd0);
        check_eq("halt_cpu", 32'(cpu_rst_n), 32'd0);
        check_eq("halt_count", 32'(load_count), 32'd2);
        check_eq("halt_sum", 32'(load_sum), 32'h83);
        fetch_addr = 8'h08;
        step();
        check_eq("halt_ram", 32'(fetch_data), 32'h9C);
        repeat (TO + 2) step();
        check_eq("halt_stays", 32'(cpu_rst_n), 32'd0);

        // Asynchronous reset in the middle of a load
        write_pulse(8'h09, 8'h44);
        check_eq("arst_pre_loading", 32'(loading), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_loading", 32'(loading), 32'd0);
        check_eq("arst_cpu", 32'(cpu_rst_n), 32'd0);
        check_eq("arst_count", 32'(load_count), 32'd0);
        check_eq("arst_sum", 32'(load_sum), 32'd0);
        check_eq("arst_fetch", 32'(fetch_data), 32'd0);
        rst_n = 1'b1;
        fetch_addr = 8'h01;
        step();
        check_eq("arst_keep_01", 32'(fetch_data), 32'h22);
        fetch_addr = 8'h09;
        step();
        check_eq("arst_keep_09", 32'(fetch_data), 32'h44);
        fetch_addr = 8'h05;
        step();
        check_eq("arst_keep_05", 32'(fetch_data), 32'h7E);
        check_eq("arst_halt", 32'(loading), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
